// File: rtl/charlie_frame_loader.sv
// Serialises a parallel LED frame into the charlieplex scan stage shift chain.
// Holds the scan stage in load while bits shift, then enforces a display dwell.
module charlie_frame_loader #(
  parameter int FRAME_BITS = 20,
  parameter int MIN_DWELL  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  ser_data,
  output logic                  ser_run,
  output logic                  busy
);

  localparam int BC_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DC_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(FRAME_BITS - 1);
  localparam logic [DC_W-1:0] DWELL_LAST = (MIN_DWELL > 0) ? DC_W'(MIN_DWELL - 1) : '0;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2,
    S_DWELL = 2'd3
  } state_t;

  // With no dwell requested, a finished frame goes straight back to IDLE.
  localparam state_t AFTER_FRAME = (MIN_DWELL == 0) ? S_IDLE : S_DWELL;

  state_t                  state_q;
  logic [BC_W-1:0]         bit_cnt_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [DC_W-1:0]         dwell_cnt_q;
  logic                    ser_data_q;
  logic                    ser_run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      dwell_cnt_q <= '0;
      ser_data_q  <= 1'b0;
      ser_run_q   <= 1'b0;
    end else begin
      case (state_q)
        // Shift FRAME_BITS zeros so the downstream chain starts dark.
        S_CLEAR: begin
          ser_data_q <= 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            ser_run_q   <= 1'b1;
            bit_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            state_q     <= AFTER_FRAME;
          end else begin
            ser_run_q <= 1'b0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        S_IDLE: begin
          if (frame_valid) begin
            // MSB goes out on the accept edge itself; the rest waits in shreg.
            shreg_q    <= {frame_data[FRAME_BITS-2:0], 1'b0};
            ser_data_q <= frame_data[FRAME_BITS-1];
            ser_run_q  <= 1'b0;
            bit_cnt_q  <= '0;
            state_q    <= S_LOAD;
          end else begin
            ser_data_q <= 1'b0;
            ser_run_q  <= 1'b1;
          end
        end

        S_LOAD: begin
          if (bit_cnt_q == BIT_LAST) begin
            ser_run_q   <= 1'b1;
            ser_data_q  <= 1'b0;
            bit_cnt_q   <= '0;
            dwell_cnt_q <= '0;
            state_q     <= AFTER_FRAME;
          end else begin
            ser_data_q <= shreg_q[FRAME_BITS-1];
            shreg_q    <= {shreg_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
          end
        end

        S_DWELL: begin
          ser_run_q  <= 1'b1;
          ser_data_q <= 1'b0;
          if (dwell_cnt_q == DWELL_LAST) begin
            dwell_cnt_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 1'b1;
          end
        end

        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign frame_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ser_data    = ser_data_q;
  assign ser_run     = ser_run_q;

endmodule
